mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 select mux among four requesters.
It produces the 2-bit mux select and a one-hot grant, and holds each grant until the owner signals last, drops its request, or exceeds a beat limit.
It sits beside the 4:1 MUX in the datapath and is the only driver of its sel input.

---
 rtl/mux4_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux; grant, select and busy are registered (one cycle from req).
// A grant is held until the owner marks last, drops its request, or has held it for HOLD_MAX cycles.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_release;
    logic             w_hold_done;
    logic [1:0]       w_arb_ptr;
    logic [2:0]       w_pick;
    logic             w_found;
    logic [1:0]       w_win;

    // Returns {found, index} of the first set bit searched upward from p, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] k;
        res = {1'b0, p};
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign w_hold_done = (r_cnt == CNT_W'(HOLD_MAX));
    assign w_release   = (r_state == GRANT) &&
                         ((last[r_sel] & req[r_sel]) | !req[r_sel] | w_hold_done);
    // On release the pointer moves past the owner before arbitrating, so the owner wins only when alone.
    assign w_arb_ptr   = w_release ? (r_sel + 2'd1) : r_ptr;
    assign w_pick      = pick(req, w_arb_ptr);
    assign w_found     = w_pick[2];
    assign w_win       = w_pick[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_arb_ptr;
                    if (w_found) begin
                        w_sel_nxt = w_win;
                        w_gnt_nxt = 4'b0001 << w_win;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_cnt_nxt   = '0;
                    end
                end else if (!w_hold_done) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = (r_state == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=2) share stimulus; each vector names the one it checks.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt4, gnt2;
    logic [1:0] sel4, sel2;
    logic       busy4, busy2;

    int n_checks = 0;
    int n_pass   = 0;
    bit inv_en   = 0;

    typedef struct {
        bit         rst;
        bit         u2;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        bit         u2;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) u_arb4 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .gnt(gnt4), .sel(sel4), .busy(busy4)
    );

    mux4_rr_arbiter #(.HOLD_MAX(2), .CNT_W(8)) u_arb2 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .gnt(gnt2), .sel(sel2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    function automatic string fmt(input logic [3:0] g, input logic [1:0] s, input logic b);
        return $sformatf("gnt=%b sel=%0d busy=%b", g, s, b);
    endfunction

    function automatic vec_t v(input bit rs, input bit u, input logic [3:0] r, input logic [3:0] l,
                               input logic [3:0] g, input logic [1:0] s, input logic b);
        vec_t x;
        x.rst = rs; x.u2 = u; x.req = r; x.last = l; x.gnt = g; x.sel = s; x.busy = b;
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        #1;
        check({gnt4, sel4, busy4} == 7'b0, "reset_h4", fmt(gnt4, sel4, busy4), fmt(4'b0, 2'd0, 1'b0));
        check({gnt2, sel2, busy2} == 7'b0, "reset_h2", fmt(gnt2, sel2, busy2), fmt(4'b0, 2'd0, 1'b0));
        inv_en = 1'b1;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb, input bit u2, input string name);
        exp_t e;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        last  = l;
        e.gnt = eg; e.sel = es; e.busy = eb; e.u2 = u2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        g = e.u2 ? gnt2 : gnt4;
        s = e.u2 ? sel2 : sel4;
        b = e.u2 ? busy2 : busy4;
        check({g, s, b} == {e.gnt, e.sel, e.busy}, name, fmt(g, s, b), fmt(e.gnt, e.sel, e.busy));
    endtask

    // Invariants: one-hot-or-zero grant, busy iff grant, and the granted line matches sel.
    always @(negedge clk) begin
        if (inv_en) begin
            check($onehot0(gnt4) && (busy4 == |gnt4) && (!busy4 || gnt4[sel4]),
                  "invariant_h4", fmt(gnt4, sel4, busy4), "onehot0 grant consistent with sel/busy");
            check($onehot0(gnt2) && (busy2 == |gnt2) && (!busy2 || gnt2[sel2]),
                  "invariant_h2", fmt(gnt2, sel2, busy2), "onehot0 grant consistent with sel/busy");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;

        // single requester B, last on third grant cycle with request dropping
        tbl.push_back(v(1, 0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(0, 0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(0, 0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(0, 0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0));
        tbl.push_back(v(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0));
        // all requesting, all last: one-cycle grants rotating with no bubble
        tbl.push_back(v(1, 0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(0, 0, 4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(0, 0, 4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 0, 4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(0, 0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1));
        // hold limit of 4 between A and C
        tbl.push_back(v(1, 0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1));
        // D granted, foreign last/req ignored, then D drops and pointer wraps to A
        tbl.push_back(v(1, 0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(0, 0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(0, 0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1));
        // HOLD_MAX=2: sole owner C re-granted, its count restarts so A waits two full cycles
        tbl.push_back(v(1, 1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(0, 1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].req, tbl[i].last, tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].u2,
                 $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of C's grant, then D wins from pointer 0
        do_reset();
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "rst_pre_grant");
        #2;
        rst_n = 1'b0;
        #1;
        check({gnt4, sel4, busy4} == 7'b0, "rst_async_mid_grant",
              fmt(gnt4, sel4, busy4), fmt(4'b0, 2'd0, 1'b0));
        step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "rst_release_grant_d");
        step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "rst_sole_regrant_d");

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
